// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: request/response handshake with the data cache,
// store lane masking/shifting, load alignment/extension and pipeline stall generation.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid_i,
  input  logic        ex_mem_load_i,
  input  logic        ex_mem_store_i,
  input  logic [2:0]  ex_mem_funct3_i,
  input  logic [31:0] ex_mem_alu_out_i,
  input  logic [31:0] ex_mem_rs2_out_i,
  output logic [31:0] dmem_address_o,
  output logic        dmem_read_o,
  output logic        dmem_write_o,
  output logic [3:0]  dmem_wmask_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_resp_i,
  output logic        mem_stall_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_rdata_valid_o,
  output logic [1:0]  mem_fault_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        fault_r;
  logic              is_load_r;
  logic [2:0]        funct3_r;
  logic [1:0]        addr_lo_r;
  logic [31:0]       address_r;
  logic              read_r;
  logic              write_r;
  logic [3:0]        wmask_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;
  logic              rdata_valid_r;

  logic memop_s;
  logic bad_s;
  logic start_s;
  logic illegal_s;
  logic timeout_s;

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'd0:    store_mask = 4'b0001 << a;
      2'd1:    store_mask = 4'b0011 << {a[1], 1'b0};
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {a, 3'b000};
    case (f3)
      3'd0:    load_align = {{24{sh[7]}}, sh[7:0]};
      3'd1:    load_align = {{16{sh[15]}}, sh[15:0]};
      3'd4:    load_align = {24'h000000, sh[7:0]};
      3'd5:    load_align = {16'h0000, sh[15:0]};
      default: load_align = rdata;
    endcase
  endfunction

  // Illegal width codes and misaligned halfword/word addresses.
  function automatic logic access_bad(input logic load, input logic [2:0] f3, input logic [1:0] a);
    logic code_bad;
    logic mis;
    code_bad = load ? ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7)) : (f3 >= 3'd3);
    mis      = ((f3[1:0] == 2'd1) && a[0]) || ((f3[1:0] == 2'd2) && (a != 2'd0));
    access_bad = code_bad || mis;
  endfunction

  assign memop_s   = ex_mem_valid_i & (ex_mem_load_i ^ ex_mem_store_i);
  assign bad_s     = access_bad(ex_mem_load_i, ex_mem_funct3_i, ex_mem_alu_out_i[1:0]);
  assign start_s   = (state_r == IDLE) & memop_s & ~bad_s;
  assign illegal_s = (state_r == IDLE) & ex_mem_valid_i &
                     ((ex_mem_load_i & ex_mem_store_i) | (memop_s & bad_s));
  assign timeout_s = (TIMEOUT != 0) && (cnt_r == CNT_W'(TIMEOUT - 1));

  assign mem_stall_o       = start_s | (state_r == ACCESS);
  assign dmem_address_o    = address_r;
  assign dmem_read_o       = read_r;
  assign dmem_write_o      = write_r;
  assign dmem_wmask_o      = wmask_r;
  assign dmem_wdata_o      = wdata_r;
  assign mem_rdata_o       = rdata_r;
  assign mem_rdata_valid_o = rdata_valid_r;

  // Fault reporting: immediate for illegal accesses, latched value during DONE.
  always_comb begin
    mem_fault_o = 2'b00;
    if (state_r == IDLE) begin
      mem_fault_o = illegal_s ? 2'b01 : 2'b00;
    end else if (state_r == DONE) begin
      mem_fault_o = fault_r;
    end else begin
      mem_fault_o = 2'b00;
    end
  end

  // Access FSM with captured request, watchdog and load result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      fault_r       <= 2'b00;
      is_load_r     <= 1'b0;
      funct3_r      <= 3'd0;
      addr_lo_r     <= 2'd0;
      address_r     <= 32'h0000_0000;
      read_r        <= 1'b0;
      write_r       <= 1'b0;
      wmask_r       <= 4'b0000;
      wdata_r       <= 32'h0000_0000;
      rdata_r       <= 32'h0000_0000;
      rdata_valid_r <= 1'b0;
    end else begin
      rdata_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r   <= ACCESS;
            cnt_r     <= {CNT_W{1'b0}};
            fault_r   <= 2'b00;
            is_load_r <= ex_mem_load_i;
            funct3_r  <= ex_mem_funct3_i;
            addr_lo_r <= ex_mem_alu_out_i[1:0];
            address_r <= {ex_mem_alu_out_i[31:2], 2'b00};
            read_r    <= ex_mem_load_i;
            write_r   <= ex_mem_store_i;
            wmask_r   <= ex_mem_store_i ? store_mask(ex_mem_funct3_i, ex_mem_alu_out_i[1:0]) : 4'b0000;
            wdata_r   <= ex_mem_store_i ? (ex_mem_rs2_out_i << {ex_mem_alu_out_i[1:0], 3'b000})
                                        : 32'h0000_0000;
          end
        end
        ACCESS: begin
          if (dmem_resp_i) begin
            state_r       <= DONE;
            read_r        <= 1'b0;
            write_r       <= 1'b0;
            rdata_valid_r <= is_load_r;
            if (is_load_r) begin
              rdata_r <= load_align(funct3_r, addr_lo_r, dmem_rdata_i);
            end
          end else if (timeout_s) begin
            state_r       <= DONE;
            fault_r       <= 2'b10;
            read_r        <= 1'b0;
            write_r       <= 1'b0;
            rdata_valid_r <= is_load_r;
          end else if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
